// File: rtl/bit_density_pkg.sv
// Shared types and helpers for the bit-density monitor family.
// Holds the FSM state type, default alarm thresholds and a saturating adder.
package bit_density_pkg;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    localparam int DEF_THRESH_HI = 160;
    localparam int DEF_THRESH_LO = 96;

    // Saturating add clamped to 2^width-1; operands are passed zero-extended.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] s;
        logic [31:0] max;
        max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        s   = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/density_hysteresis.sv
// Hysteretic threshold flag: sets at or above THRESH_HI, clears at or below
// THRESH_LO, holds in between. Only re-evaluated when update_i is high.
module density_hysteresis #(
    parameter int SUM_WIDTH = 8,
    parameter int THRESH_HI = 160,
    parameter int THRESH_LO = 96
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 update_i,
    input  logic [SUM_WIDTH-1:0] sum_i,
    output logic                 alarm_o
);

    localparam logic [31:0] HI = THRESH_HI;
    localparam logic [31:0] LO = THRESH_LO;

    logic alarm_q, alarm_d;

    // Next alarm value from the freshly published sum.
    always_comb begin
        alarm_d = alarm_q;
        if (update_i) begin
            if (32'(sum_i) >= HI)
                alarm_d = 1'b1;
            else if (32'(sum_i) <= LO)
                alarm_d = 1'b0;
        end
    end

    // Alarm register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) alarm_q <= 1'b0;
        else       alarm_q <= alarm_d;
    end

    assign alarm_o = alarm_q;

endmodule

// File: rtl/bit_density_monitor.sv
// Tumbling-window sum of popcount words with a hysteretic density alarm.
// Optional feature macro DENSITY_PEAK_EN adds a Peak output holding the
// largest window sum seen since reset or Clear.
module bit_density_monitor
    import bit_density_pkg::*;
#(
    parameter int COUNT_WIDTH = 4,
    parameter int WINDOW_LEN  = 16,
    parameter int SUM_WIDTH   = 8,
    parameter int THRESH_HI   = DEF_THRESH_HI,
    parameter int THRESH_LO   = DEF_THRESH_LO
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Clear,
    input  logic                          CountValid,
    input  logic [COUNT_WIDTH-1:0]        CountIn,
    output logic [SUM_WIDTH-1:0]          Sum,
    output logic                          SumValid,
    output logic                          Alarm,
    output logic [$clog2(WINDOW_LEN)-1:0] SampleIdx
`ifdef DENSITY_PEAK_EN
    ,
    output logic [SUM_WIDTH-1:0]          Peak
`endif
);

    localparam int              IDX_W    = $clog2(WINDOW_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_LEN - 1);

    state_e               state_q, state_d;
    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic                 sum_valid_q, sum_valid_d;
    logic [SUM_WIDTH-1:0] acc_plus;

    // acc_q is zero in IDLE, so one adder serves both the open and add paths.
    assign acc_plus = SUM_WIDTH'(sat_add(32'(acc_q), 32'(CountIn), SUM_WIDTH));

    // Window FSM: open on first sample, accumulate, close on the last sample.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        if (Clear) begin
            // Abort drops the partial window and any coincident sample.
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else if (CountValid) begin
            case (state_q)
                IDLE: begin
                    state_d = ACCUM;
                    acc_d   = acc_plus;
                    idx_d   = IDX_W'(1);
                end
                ACCUM: begin
                    if (idx_q == LAST_IDX) begin
                        // Stay in ACCUM so the next cycle's sample opens a new window.
                        sum_d       = acc_plus;
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        idx_d       = '0;
                    end else begin
                        acc_d = acc_plus;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Window state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    density_hysteresis #(
        .SUM_WIDTH (SUM_WIDTH),
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO)
    ) u_hyst (
        .clk_i    (CLK),
        .rst_i    (RST),
        .update_i (sum_valid_d),
        .sum_i    (sum_d),
        .alarm_o  (Alarm)
    );

`ifdef DENSITY_PEAK_EN
    logic [SUM_WIDTH-1:0] peak_q, peak_d;

    // Running maximum of completed window sums; Clear restarts it.
    always_comb begin
        peak_d = peak_q;
        if (Clear)
            peak_d = '0;
        else if (sum_valid_d && (sum_d > peak_q))
            peak_d = sum_d;
    end

    // Peak register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign Peak = peak_q;
`endif

    assign Sum       = sum_q;
    assign SumValid  = sum_valid_q;
    assign SampleIdx = idx_q;

endmodule

// File: tb/tb_bit_density_monitor.sv
// Bench for bit_density_monitor: scoreboard of expected window results popped
// on every SumValid, plus directed checks of index, reset, Clear and saturation.
module tb_bit_density_monitor;

    logic       CLK = 1'b0;
    logic       RST, Clear, CountValid;
    logic [3:0] CountIn;
    logic [7:0] Sum;
    logic       SumValid, Alarm;
    logic [3:0] SampleIdx;

    logic       Clear2, CountValid2;
    logic [3:0] CountIn2;
    logic [5:0] Sum2;
    logic       SumValid2, Alarm2;
    logic [3:0] SampleIdx2;
`ifdef DENSITY_PEAK_EN
    logic [7:0] Peak;
    logic [5:0] Peak2;
`endif

    always #5 CLK = ~CLK;

    bit_density_monitor dut (
        .CLK(CLK), .RST(RST), .Clear(Clear), .CountValid(CountValid),
        .CountIn(CountIn), .Sum(Sum), .SumValid(SumValid), .Alarm(Alarm),
        .SampleIdx(SampleIdx)
`ifdef DENSITY_PEAK_EN
        , .Peak(Peak)
`endif
    );

    bit_density_monitor #(.SUM_WIDTH(6)) dut6 (
        .CLK(CLK), .RST(RST), .Clear(Clear2), .CountValid(CountValid2),
        .CountIn(CountIn2), .Sum(Sum2), .SumValid(SumValid2), .Alarm(Alarm2),
        .SampleIdx(SampleIdx2)
`ifdef DENSITY_PEAK_EN
        , .Peak(Peak2)
`endif
    );

    typedef struct {
        logic [7:0] sum;
        logic       alarm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input bit a);
        exp_t e;
        e.sum   = s[7:0];
        e.alarm = a;
        q.push_back(e);
    endtask

    task automatic send(input int v);
        CountValid = 1'b1;
        CountIn    = v[3:0];
        @(posedge CLK); #1;
        CountValid = 1'b0;
    endtask

    task automatic send2(input int v);
        CountValid2 = 1'b1;
        CountIn2    = v[3:0];
        @(posedge CLK); #1;
        CountValid2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Monitor: every SumValid pulse must match the oldest expected window.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && SumValid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sumvalid: got Sum=%0d with no window expected", Sum);
                end else begin
                    e = q.pop_front();
                    check("sb_sum", 32'(Sum), 32'(e.sum));
                    check("sb_alarm", 32'(Alarm), 32'(e.alarm));
                end
            end
        end
    end

    initial begin
        RST = 1'b1; Clear = 1'b0; CountValid = 1'b0; CountIn = '0;
        Clear2 = 1'b0; CountValid2 = 1'b0; CountIn2 = '0;
        #12;
        check("rst_sum", 32'(Sum), 0);
        check("rst_sumvalid", 32'(SumValid), 0);
        check("rst_alarm", 32'(Alarm), 0);
        check("rst_idx", 32'(SampleIdx), 0);
`ifdef DENSITY_PEAK_EN
        check("rst_peak", 32'(Peak), 0);
`endif
        @(posedge CLK); #1;
        RST = 1'b0;

        // Back-to-back windows, no bubble between them.
        push(160, 1'b1);
        push(160, 1'b1);
        for (int i = 0; i < 32; i++) begin
            send(10);
            check("b2b_idx", 32'(SampleIdx), 32'((i + 1) % 16));
            if (i == 14 || i == 30) check("b2b_sv_early", 32'(SumValid), 0);
            if (i == 15 || i == 31) begin
                check("b2b_sv", 32'(SumValid), 1);
                check("b2b_alarm", 32'(Alarm), 1);
            end
        end

        // Reset mid-window wipes everything immediately.
        repeat (5) send(7);
        check("mid_idx", 32'(SampleIdx), 5);
        #2 RST = 1'b1;
        #1;
        check("midrst_sum", 32'(Sum), 0);
        check("midrst_idx", 32'(SampleIdx), 0);
        check("midrst_alarm", 32'(Alarm), 0);
        check("midrst_sv", 32'(SumValid), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        push(48, 1'b0);
        repeat (16) send(3);
        check("w48_sv", 32'(SumValid), 1);

        // Hysteresis: 160, 120, 96, 120 -> 1, 1, 0, 0.
        push(160, 1'b1);
        repeat (16) send(10);
        push(120, 1'b1);
        repeat (8) send(8);
        repeat (8) send(7);
        check("hyst_hold1", 32'(Alarm), 1);
        push(96, 1'b0);
        repeat (16) send(6);
        push(120, 1'b0);
        repeat (8) send(8);
        repeat (8) send(7);
        check("hyst_hold0", 32'(Alarm), 0);

        // Gapped valid: index holds through idle cycles.
        push(240, 1'b1);
        for (int k = 0; k < 16; k++) begin
            send(15);
            if (k < 15) begin
                idle(k % 4);
                check("gap_idx", 32'(SampleIdx), 32'(k + 1));
            end
        end
        check("gap_sv", 32'(SumValid), 1);
        check("gap_sum", 32'(Sum), 240);
`ifdef DENSITY_PEAK_EN
        check("gap_peak", 32'(Peak), 240);
`endif

        // Clear collides with the closing sample: window discarded.
        repeat (15) send(2);
        check("clr_pre_idx", 32'(SampleIdx), 15);
        Clear = 1'b1;
        send(2);
        Clear = 1'b0;
        check("clr_sv", 32'(SumValid), 0);
        check("clr_idx", 32'(SampleIdx), 0);
        check("clr_sum", 32'(Sum), 240);
        check("clr_alarm", 32'(Alarm), 1);
`ifdef DENSITY_PEAK_EN
        check("clr_peak", 32'(Peak), 0);
`endif
        idle(1);
        check("clr_sv_next", 32'(SumValid), 0);

        // Fresh window after Clear starts from IDLE.
        push(16, 1'b0);
        repeat (16) send(1);

        // Saturation on the 6-bit instance.
        repeat (5) send2(15);
        check("sat_idx", 32'(SampleIdx2), 5);
        repeat (11) send2(15);
        check("sat_sv", 32'(SumValid2), 1);
        check("sat_sum", 32'(Sum2), 63);
        check("sat_alarm", 32'(Alarm2), 0);
`ifdef DENSITY_PEAK_EN
        check("sat_peak", 32'(Peak2), 63);
`endif
        Clear2 = 1'b1;
        idle(1);
        Clear2 = 1'b0;
        check("sat_clr_sum", 32'(Sum2), 63);
        check("sat_clr_idx", 32'(SampleIdx2), 0);
`ifdef DENSITY_PEAK_EN
        check("sat_clr_peak", 32'(Peak2), 0);
`endif

        idle(3);
        check("queue_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
